riscv_multicycle: RTL and testbench

RISCV_MULTICYCLE -- requirements
Module: riscv_multicycle

---
 rtl/riscv_multicycle.sv | 248 ++++++++++++++++++++++++
 tb/tb_riscv_multicycle.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multi-cycle RV32I-subset core with one unified memory port.
// Supports lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, bne,
// blt and jal. Any other encoding, or a misaligned lw/sw address, parks the
// core in HALT with trap=1 until reset.
// Ports:
//   clk        - single clock, rising edge
//   areset     - synchronous active-high reset
//   mem_req    - memory transaction request
//   mem_we     - 1 = write, 0 = read (valid while mem_req=1)
//   mem_addr   - word-aligned byte address
//   mem_wdata  - store data
//   mem_rdata  - read data, taken when mem_req and mem_ready are both 1
//   mem_ready  - completes the current transaction in the same cycle
//   retire     - one-cycle pulse in the last cycle of each instruction
//   trap       - high while halted
//   pc_out     - address of the instruction in flight
module riscv_multicycle #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             areset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             retire,
    output logic             trap,
    output logic [WIDTH-1:0] pc_out
);

    localparam int RIW = $clog2(NUM_REGS);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(32'd4);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, oldpc_q, ir_q, a_q, b_q, target_q, addr_q, data_q;
    logic [WIDTH-1:0] rf_q [NUM_REGS];

    // Instruction fields and sign-extended immediates
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_j;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{(WIDTH-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{(WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{(WIDTH-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Legal-encoding classification; funct3 010/110/111/000 cover slt/or/and/add
    logic alu_f3, is_load, is_store, is_rtype, is_itype, is_branch, is_jal;
    logic uses_rs1, uses_rs2, uses_rd, regs_ok;
    assign alu_f3    = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);
    assign is_load   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_store  = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_rtype  = (opcode == 7'b0110011) &&
                       (((funct7 == 7'b0000000) && alu_f3) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    assign is_itype  = (opcode == 7'b0010011) && alu_f3;
    assign is_branch = (opcode == 7'b1100011) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100));
    assign is_jal    = (opcode == 7'b1101111);
    assign uses_rs1  = is_load || is_store || is_rtype || is_itype || is_branch;
    assign uses_rs2  = is_store || is_rtype || is_branch;
    assign uses_rd   = is_load || is_rtype || is_itype || is_jal;
    // Only register fields the format actually uses are range-checked (RV32E)
    assign regs_ok   = !(uses_rs1 && (int'(rs1) >= NUM_REGS)) &&
                       !(uses_rs2 && (int'(rs2) >= NUM_REGS)) &&
                       !(uses_rd  && (int'(rd)  >= NUM_REGS));

    logic [WIDTH-1:0] rs1_val, rs2_val, eff_addr;
    assign rs1_val  = (rs1 == 5'd0) ? ZERO : rf_q[rs1[RIW-1:0]];
    assign rs2_val  = (rs2 == 5'd0) ? ZERO : rf_q[rs2[RIW-1:0]];
    assign eff_addr = a_q + (is_store ? imm_s : imm_i);

    logic [WIDTH-1:0] alu_b, alu_res;
    logic             lt, taken;

    // ALU result and branch decision
    always_comb begin
        alu_b   = (state_q == S_EXECI) ? imm_i : b_q;
        lt      = $signed(a_q) < $signed(alu_b);
        alu_res = ZERO;
        taken   = 1'b0;
        case (funct3)
            3'b000: begin
                if ((state_q == S_EXECR) && ir_q[30]) begin
                    alu_res = a_q - alu_b;
                end else begin
                    alu_res = a_q + alu_b;
                end
                taken = (a_q == b_q);
            end
            3'b001:  taken   = (a_q != b_q);
            3'b010:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            3'b100:  taken   = lt;
            3'b110:  alu_res = a_q | alu_b;
            3'b111:  alu_res = a_q & alu_b;
            default: alu_res = ZERO;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!regs_ok)                    state_d = S_HALT;
                else if (is_load || is_store)    state_d = S_MEMADR;
                else if (is_rtype)               state_d = S_EXECR;
                else if (is_itype)               state_d = S_EXECI;
                else if (is_branch)              state_d = S_BRANCH;
                else if (is_jal)                 state_d = S_JAL;
                else                             state_d = S_HALT;
            end
            S_MEMADR: begin
                if (eff_addr[1:0] != 2'b00)      state_d = S_HALT;
                else if (is_load)                state_d = S_MEMRD;
                else                             state_d = S_MEMWR;
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR, S_EXECI:            state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    logic             wb_en;
    logic [WIDTH-1:0] wb_data;
    assign wb_en   = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_JAL);
    assign wb_data = (state_q == S_JAL) ? (oldpc_q + FOUR) : data_q;

    // Datapath registers and register file
    always_ff @(posedge clk) begin
        if (areset) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= RESET_PC;
            ir_q     <= ZERO;
            a_q      <= ZERO;
            b_q      <= ZERO;
            target_q <= ZERO;
            addr_q   <= ZERO;
            data_q   <= ZERO;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= ZERO;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        oldpc_q <= pc_q;
                        pc_q    <= pc_q + FOUR;
                    end
                end
                S_DECODE: begin
                    a_q      <= rs1_val;
                    b_q      <= rs2_val;
                    target_q <= oldpc_q + (is_jal ? imm_j : imm_b);
                end
                S_MEMADR: addr_q <= eff_addr;
                S_MEMRD: begin
                    if (mem_ready) begin
                        data_q <= mem_rdata;
                    end
                end
                S_EXECR, S_EXECI: data_q <= alu_res;
                S_BRANCH: begin
                    if (taken) begin
                        pc_q <= target_q;
                    end
                end
                S_JAL:   pc_q <= target_q;
                default: ;
            endcase
            // x0 is never written so it always reads back as zero
            if (wb_en && (rd != 5'd0)) begin
                rf_q[rd[RIW-1:0]] <= wb_data;
            end
        end
    end

    // Output decode; reset forces every output to its idle value immediately
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ZERO;
        mem_wdata = ZERO;
        retire    = 1'b0;
        trap      = 1'b0;
        pc_out    = oldpc_q;
        if (areset) begin
            pc_out = RESET_PC;
        end else begin
            case (state_q)
                S_IDLE:  pc_out = pc_q;
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    pc_out   = pc_q;
                end
                S_MEMRD: begin
                    mem_req  = 1'b1;
                    mem_addr = addr_q;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = b_q;
                    retire    = mem_ready;
                end
                S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: retire = 1'b1;
                S_HALT:  trap = 1'b1;
                default: pc_out = oldpc_q;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle.sv
module tb_riscv_multicycle;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        retire, trap;
    logic [31:0] pc_out;

    logic        areset16 = 1'b1;
    logic        mem_req16, mem_we16, retire16, trap16;
    logic [31:0] mem_addr16, mem_wdata16, mem_rdata16, pc_out16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_multicycle dut (
        .clk(clk), .areset(areset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .retire(retire), .trap(trap), .pc_out(pc_out)
    );

    riscv_multicycle #(.RESET_PC(32'h0000_0040), .NUM_REGS(16)) dut16 (
        .clk(clk), .areset(areset16), .mem_req(mem_req16), .mem_we(mem_we16),
        .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16),
        .mem_ready(1'b1), .retire(retire16), .trap(trap16), .pc_out(pc_out16)
    );

    // Memory models: program words loaded by the bench, stores kept separately
    logic [31:0] mem_q   [64];
    logic [31:0] st_q    [64];
    bit          st_v    [64];
    logic [31:0] mem16_q [64];
    int          wr_cnt = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

    assign mem_rdata   = st_v[mem_addr[7:2]] ? st_q[mem_addr[7:2]] : mem_q[mem_addr[7:2]];
    assign mem_rdata16 = mem16_q[mem_addr16[7:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) begin
            st_q[mem_addr[7:2]] <= mem_wdata;
            st_v[mem_addr[7:2]] <= 1'b1;
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [31:0] exp_pc);
        check32({name, " req/we/retire/trap"}, {28'd0, mem_req, mem_we, retire, trap}, 32'd0);
        check32({name, " addr"},   mem_addr,  32'd0);
        check32({name, " wdata"},  mem_wdata, 32'd0);
        check32({name, " pc_out"}, pc_out,    exp_pc);
    endtask

    // Reset the main core; returns at the negedge of the IDLE cycle
    task automatic do_reset;
        areset = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        check_idle_outputs("in reset", 32'd0);
        @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after reset", 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          cyc;
        int          waits;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    initial begin
        // Execution trace of the main program, in order (0x08..0x10 run twice)
        tv[0]  = '{32'h00, enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'b0010011), 5'd1,  32'd5,        4, 0};
        tv[1]  = '{32'h04, enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011), 5'd2,  32'hFFFFFFFD, 4, 0};
        tv[2]  = '{32'h08, enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3),          5'd3,  32'd2,        4, 0};
        tv[3]  = '{32'h0C, enc_i(12'd2,   5'd9, 3'b000, 5'd9, 7'b0010011), 5'd9,  32'd2,        4, 0};
        tv[4]  = '{32'h10, enc_b(13'h1FF8, 5'd3, 5'd9, 3'b000),            5'd0,  32'd0,        3, 0};
        tv[5]  = '{32'h08, enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3),          5'd3,  32'd2,        4, 0};
        tv[6]  = '{32'h0C, enc_i(12'd2,   5'd9, 3'b000, 5'd9, 7'b0010011), 5'd9,  32'd4,        4, 0};
        tv[7]  = '{32'h10, enc_b(13'h1FF8, 5'd3, 5'd9, 3'b000),            5'd0,  32'd0,        3, 0};
        tv[8]  = '{32'h14, enc_r(7'd0, 5'd1, 5'd2, 3'b010, 5'd4),          5'd4,  32'd1,        4, 0};
        tv[9]  = '{32'h18, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd5),    5'd5,  32'hFFFFFFF8, 4, 0};
        tv[10] = '{32'h1C, enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd6),          5'd6,  32'd5,        4, 0};
        tv[11] = '{32'h20, enc_j(21'h10, 5'd1),                            5'd1,  32'h24,       3, 0};
        tv[12] = '{32'h30, enc_r(7'd0, 5'd4, 5'd5, 3'b110, 5'd7),          5'd7,  32'hFFFFFFF9, 4, 0};
        tv[13] = '{32'h34, enc_i(12'h00F, 5'd7, 3'b111, 5'd8, 7'b0010011), 5'd8,  32'd9,        4, 0};
        tv[14] = '{32'h38, enc_i(12'hF00, 5'd0, 3'b110, 5'd10, 7'b0010011), 5'd10, 32'hFFFFFF00, 4, 0};
        tv[15] = '{32'h3C, enc_b(13'h0008, 5'd4, 5'd5, 3'b100),            5'd0,  32'd0,        3, 0};
        tv[16] = '{32'h44, enc_b(13'h0008, 5'd4, 5'd4, 3'b001),            5'd0,  32'd0,        3, 0};
        tv[17] = '{32'h48, enc_i(12'h080, 5'd0, 3'b010, 5'd1, 7'b0000011), 5'd1,  32'hDEADBEEF, 5, 0};
        tv[18] = '{32'h4C, enc_s(12'h008, 5'd1, 5'd0),                     5'd0,  32'd0,        4, 0};
        tv[19] = '{32'h50, enc_i(12'h008, 5'd0, 3'b010, 5'd5, 7'b0000011), 5'd5,  32'hDEADBEEF, 5, 0};
        tv[20] = '{32'h54, enc_i(12'hFFE, 5'd2, 3'b010, 5'd11, 7'b0010011), 5'd11, 32'd1,       7, 3};
        tv[21] = '{32'h58, enc_i(12'd7,   5'd1, 3'b000, 5'd0, 7'b0010011), 5'd0,  32'd0,        4, 0};

        for (int i = 0; i < 64; i++) begin
            mem_q[i]   = 32'd0;
            mem16_q[i] = 32'd0;
        end
        for (int i = 0; i < NV; i++) begin
            mem_q[tv[i].addr[7:2]] = tv[i].instr;
        end
        mem_q[32] = 32'hDEADBEEF;

        mem16_q[16] = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011);
        mem16_q[17] = enc_i(12'd4, 5'd1, 3'b000, 5'd0, 7'b0010011);
        mem16_q[18] = enc_r(7'd0, 5'd1, 5'd0, 3'b000, 5'd2);
        mem16_q[19] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd17);

        // ---- Main program, table driven ----
        do_reset();
        for (int i = 0; i < NV; i++) begin
            int cyc;
            bit done;
            cyc  = 0;
            done = 1'b0;
            if (tv[i].waits > 0) mem_ready = 1'b0;
            while (!done && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) begin
                    check32($sformatf("fetch[%0d] req/we", i), {30'd0, mem_req, mem_we}, 32'd2);
                    check32($sformatf("fetch[%0d] addr", i), mem_addr, tv[i].addr);
                end
                if (tv[i].waits > 0 && cyc <= tv[i].waits + 1) begin
                    check32($sformatf("hold[%0d] cyc%0d", i, cyc), {mem_req, mem_addr[30:0]},
                            {1'b1, tv[i].addr[30:0]});
                    if (cyc == tv[i].waits + 1) mem_ready = 1'b1;
                end
                if (retire) done = 1'b1;
            end
            check32($sformatf("cycles[%0d]", i), 32'(cyc), 32'(tv[i].cyc));
            check32($sformatf("pc_out[%0d]", i), pc_out, tv[i].addr);
            @(posedge clk);
            #1;
            check32($sformatf("rd[%0d] x%0d", i, tv[i].rd), dut.rf_q[tv[i].rd], tv[i].exp);
        end
        check32("store count", 32'(wr_cnt), 32'd1);
        check32("store addr", last_waddr, 32'd8);
        check32("store data", last_wdata, 32'hDEADBEEF);

        // Illegal opcode at 0x5C
        for (int k = 0; k < 10 && !trap; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check32("illegal trap/req/retire", {29'd0, trap, mem_req, retire}, 32'd4);
        check32("illegal pc_out", pc_out, 32'h5C);

        // ---- Misaligned lw x1,3(x0) ----
        mem_q[0] = enc_i(12'h003, 5'd0, 3'b010, 5'd1, 7'b0000011);
        do_reset();
        check32("regs cleared by reset", dut.rf_q[1], 32'd0);
        for (int k = 0; k < 10 && !trap; k++) @(negedge clk);
        @(negedge clk);
        check32("misalign trap/req", {30'd0, trap, mem_req}, 32'd2);
        check32("misalign pc_out", pc_out, 32'd0);
        check32("misalign no load", dut.rf_q[1], 32'd0);

        // ---- Reset during a stalled store: sw x0,8(x0) ----
        mem_q[0] = enc_s(12'h008, 5'd0, 5'd0);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 10 && !mem_we; k++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check32($sformatf("stall hold %0d", k), {mem_req, mem_we, mem_addr[29:0]},
                    {2'b11, 30'd8});
            @(negedge clk);
        end
        do_reset();
        @(negedge clk);
        check32("refetch req/we", {30'd0, mem_req, mem_we}, 32'd2);
        check32("refetch addr", mem_addr, 32'd0);
        check32("no store during reset", 32'(wr_cnt), 32'd1);

        // ---- RV32E instance at RESET_PC 0x40 ----
        @(posedge clk);
        @(posedge clk);
        #1 areset16 = 1'b0;
        @(negedge clk);
        check32("e16 idle pc_out", pc_out16, 32'h40);
        @(negedge clk);
        check32("e16 first fetch", {mem_req16, mem_addr16[30:0]}, {1'b1, 31'h40});
        for (int k = 0; k < 40 && !trap16; k++) @(negedge clk);
        check32("e16 trap/req", {30'd0, trap16, mem_req16}, 32'd2);
        check32("e16 pc_out", pc_out16, 32'h4C);
        check32("e16 x0", dut16.rf_q[0], 32'd0);
        check32("e16 x2", dut16.rf_q[2], 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
